// File: rtl/switch_cfg_loader.sv
// Loads one routing word per destination wire into a shadow copy, checks each
// word as it arrives, and swaps the whole set into cfg_active in a single commit.
module switch_cfg_loader #(
  parameter int NTB = 5,
  parameter int NLR = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_start,
  input  logic                             i_abort,
  input  logic                             i_in_valid,
  input  logic [5:0]                       i_in_data,
  output logic                             o_in_ready,
  output logic [6*(2*NTB+2*NLR)-1:0]       o_cfg_active,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_err,
  output logic [4:0]                       o_err_idx,
  output logic [1:0]                       o_dbg_state
);

  localparam int NW   = 2*NTB + 2*NLR;
  localparam int CW   = 6*NW;
  localparam int CNTW = $clog2(NW);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CNTW-1:0] r_cnt;
  logic [CW-1:0]   r_shadow;
  logic [CW-1:0]   r_cfg;
  logic            r_done;
  logic            r_err;
  logic [4:0]      r_err_idx;

  logic [2:0]      w_side;
  logic [2:0]      w_idx;
  logic [2:0]      w_dst_side;
  logic [2:0]      w_dst_idx;
  logic            w_in_range;
  logic            w_legal;
  logic            w_accept;
  logic            w_start_load;

  assign w_side = i_in_data[2:0];
  assign w_idx  = i_in_data[5:3];

  // Side/index of the wire being configured now, used to reject self-loops.
  always_comb begin
    w_dst_side = 3'd1;
    w_dst_idx  = 3'd0;
    if (int'(r_cnt) < NTB) begin
      w_dst_side = 3'd1;
      w_dst_idx  = 3'(int'(r_cnt));
    end else if (int'(r_cnt) < 2*NTB) begin
      w_dst_side = 3'd3;
      w_dst_idx  = 3'(int'(r_cnt) - NTB);
    end else if (int'(r_cnt) < 2*NTB + NLR) begin
      w_dst_side = 3'd4;
      w_dst_idx  = 3'(int'(r_cnt) - 2*NTB);
    end else begin
      w_dst_side = 3'd2;
      w_dst_idx  = 3'(int'(r_cnt) - 2*NTB - NLR);
    end
  end

  always_comb begin
    w_in_range = 1'b0;
    case (w_side)
      3'd0:       w_in_range = (w_idx == 3'd0);
      3'd1, 3'd3: w_in_range = (int'(w_idx) < NTB);
      3'd2, 3'd4: w_in_range = (int'(w_idx) < NLR);
      default:    w_in_range = 1'b0;
    endcase
    w_legal = w_in_range && !((w_side == w_dst_side) && (w_idx == w_dst_idx));
  end

  // Handshake: a word transfers on a rising edge where i_in_valid and
  // o_in_ready are both high; o_in_ready drops while i_abort is asserted
  // so an aborted cycle never transfers.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE:   if (i_start) w_next = S_LOAD;
      S_LOAD: begin
        if (i_abort) begin
          w_next = S_IDLE;
        end else if (i_in_valid) begin
          w_accept = 1'b1;
          if (!w_legal)                         w_next = S_ERR;
          else if (r_cnt == CNTW'(NW - 1))      w_next = S_COMMIT;
        end
      end
      S_COMMIT: w_next = S_IDLE;
      S_ERR:    if (i_start) w_next = S_LOAD;
      default:  w_next = S_IDLE;
    endcase
    w_start_load = ((r_state == S_IDLE) || (r_state == S_ERR)) && i_start;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_shadow  <= '0;
      r_cfg     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_err_idx <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_COMMIT);
      if (r_state == S_COMMIT) r_cfg <= r_shadow;
      if (w_start_load) begin
        r_cnt     <= '0;
        r_err     <= 1'b0;
        r_err_idx <= '0;
      end
      if (w_accept && w_legal) begin
        r_shadow[int'(r_cnt)*6 +: 6] <= i_in_data;
        // Saturates on the last word; the next start reloads it from zero.
        if (r_cnt != CNTW'(NW - 1)) r_cnt <= r_cnt + CNTW'(1);
      end
      if (w_accept && !w_legal) begin
        r_err     <= 1'b1;
        r_err_idx <= 5'(r_cnt);
      end
    end
  end

  assign o_in_ready   = (r_state == S_LOAD) && !i_abort && !rst;
  assign o_busy       = ((r_state == S_LOAD) || (r_state == S_COMMIT)) && !rst;
  assign o_cfg_active = r_cfg;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_err_idx    = r_err_idx;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_switch_cfg_loader.sv
// Bench for switch_cfg_loader: directed scenarios plus randomized loads checked
// against a table-driven model of destination order and word legality.
module tb_switch_cfg_loader;
  localparam int NTB = 5;
  localparam int NLR = 4;
  localparam int NW  = 2*NTB + 2*NLR;
  localparam int CW  = 6*NW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          in_valid;
  logic [5:0]    in_data;
  logic          in_ready;
  logic [CW-1:0] cfg_active;
  logic          busy;
  logic          done;
  logic          err;
  logic [4:0]    err_idx;
  logic [1:0]    dbg_state;

  int n_pass  = 0;
  int n_total = 0;
  int done_seen = 0;

  int            dest_side[NW];
  int            dest_idx[NW];
  logic [5:0]    model_shadow[NW];
  logic [CW-1:0] model_cfg;
  logic [CW-1:0] gapfree_cfg;

  switch_cfg_loader #(.NTB(NTB), .NLR(NLR)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
    .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
    .o_cfg_active(cfg_active), .o_busy(busy), .o_done(done), .o_err(err),
    .o_err_idx(err_idx), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Destination table built in wire order: top, bottom, left, right.
  task automatic build_dest_table;
    int k;
    k = 0;
    for (int i = 0; i < NTB; i++) begin dest_side[k] = 1; dest_idx[k] = i; k++; end
    for (int i = 0; i < NTB; i++) begin dest_side[k] = 3; dest_idx[k] = i; k++; end
    for (int i = 0; i < NLR; i++) begin dest_side[k] = 4; dest_idx[k] = i; k++; end
    for (int i = 0; i < NLR; i++) begin dest_side[k] = 2; dest_idx[k] = i; k++; end
  endtask

  function automatic bit model_legal(input int k, input logic [5:0] w);
    int side;
    int idx;
    int lim;
    side = int'(w[2:0]);
    idx  = int'(w[5:3]);
    if (side == 0) return (idx == 0);
    if (side > 4) return 1'b0;
    lim = (side == 1 || side == 3) ? NTB : NLR;
    if (idx >= lim) return 1'b0;
    if (side == dest_side[k] && idx == dest_idx[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [CW-1:0] model_pack();
    logic [CW-1:0] v;
    v = '0;
    for (int k = 0; k < NW; k++) v[k*6 +: 6] = model_shadow[k];
    return v;
  endfunction

  function automatic logic [5:0] pattern_word(input int k);
    logic [2:0] ix;
    ix = 3'(k % 4);
    if (k < 10) return {ix, 3'd2};
    return {3'd0, 3'd1};
  endfunction

  function automatic logic [5:0] rand_word(input int k, input bit want_legal);
    logic [5:0] w;
    w = 6'(pattern_word(k));
    for (int t = 0; t < 1000; t++) begin
      w = 6'($urandom_range(63, 0));
      if (model_legal(k, w) == want_legal) return w;
    end
    return want_legal ? pattern_word(k) : 6'h3f;
  endfunction

  // Presents one word after a random idle gap and waits (bounded) for it to transfer.
  task automatic send_word(input logic [5:0] w, input int max_gap);
    bit ok;
    ok = 1'b0;
    repeat ($urandom_range(max_gap, 0)) begin in_valid = 1'b0; tick(); end
    in_valid = 1'b1;
    in_data  = w;
    for (int t = 0; t < 20; t++) begin
      if (in_ready === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    n_total++;
    if (!ok) $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    else begin n_pass++; tick(); end
    in_valid = 1'b0;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; abort = 1'b0; in_valid = 1'b1; in_data = 6'h01;
    tick(); tick();
    n_total++; if (in_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", in_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (cfg_active !== '0) $display("FAIL reset_cfg: got %h want 0", cfg_active); else n_pass++;
    n_total++; if ({done, err, err_idx} !== 7'd0) $display("FAIL reset_flags: got %b want 0", {done, err, err_idx}); else n_pass++;
    n_total++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else n_pass++;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < NW; k++) model_shadow[k] = 6'd0;
    model_cfg = '0;
    tick();
  endtask

  task automatic test_full_load;
    int ready_cycles;
    ready_cycles = 0;
    done_seen = 0;
    do_start();
    in_valid = 1'b1;
    for (int k = 0; k < NW; k++) begin
      in_data = pattern_word(k);
      if (in_ready === 1'b1) ready_cycles++;
      model_shadow[k] = pattern_word(k);
      tick();
    end
    in_valid = 1'b0;
    n_total++; if (ready_cycles != NW) $display("FAIL full_ready_cycles: got %0d want %0d", ready_cycles, NW); else n_pass++;
    n_total++; if (done !== 1'b0 || busy !== 1'b1) $display("FAIL full_commit_cycle: done=%b busy=%b want 0/1", done, busy); else n_pass++;
    n_total++; if (cfg_active !== model_cfg) $display("FAIL full_cfg_early: got %h want %h", cfg_active, model_cfg); else n_pass++;
    model_cfg = model_pack();
    tick();
    n_total++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL full_done: done=%b busy=%b want 1/0", done, busy); else n_pass++;
    n_total++; if (cfg_active !== model_cfg) $display("FAIL full_cfg: got %h want %h", cfg_active, model_cfg); else n_pass++;
    tick();
    n_total++; if (done !== 1'b0) $display("FAIL full_done_width: got %b want 0", done); else n_pass++;
    n_total++; if (done_seen != 1) $display("FAIL full_done_count: got %0d want 1", done_seen); else n_pass++;
    gapfree_cfg = model_cfg;
  endtask

  task automatic wait_commit;
    for (int t = 0; t < 5; t++) begin
      if (done === 1'b1) break;
      tick();
    end
    tick(); tick();
  endtask

  task automatic test_gaps;
    done_seen = 0;
    do_start();
    for (int k = 0; k < NW; k++) send_word(pattern_word(k), 3);
    wait_commit();
    n_total++; if (cfg_active !== gapfree_cfg) $display("FAIL gaps_cfg: got %h want %h", cfg_active, gapfree_cfg); else n_pass++;
    n_total++; if (done_seen != 1) $display("FAIL gaps_done_count: got %0d want 1", done_seen); else n_pass++;
  endtask

  task automatic test_bad_word(input int bad_k, input logic [5:0] bad_w);
    do_start();
    for (int k = 0; k < bad_k; k++) begin
      send_word(pattern_word(k), 1);
      model_shadow[k] = pattern_word(k);
    end
    send_word(bad_w, 1);
    n_total++; if (err !== 1'b1 || err_idx !== 5'(bad_k)) $display("FAIL bad_err_%0d: err=%b idx=%0d want 1/%0d", bad_k, err, err_idx, bad_k); else n_pass++;
    n_total++; if (in_ready !== 1'b0 || dbg_state !== 2'd3) $display("FAIL bad_state_%0d: ready=%b state=%0d want 0/3", bad_k, in_ready, dbg_state); else n_pass++;
    tick(); tick();
    n_total++; if (err !== 1'b1 || err_idx !== 5'(bad_k) || cfg_active !== model_cfg) $display("FAIL bad_hold_%0d: err=%b idx=%0d cfg=%h want 1/%0d/%h", bad_k, err, err_idx, cfg_active, bad_k, model_cfg); else n_pass++;
    do_start();
    n_total++; if (err !== 1'b0 || err_idx !== 5'd0 || in_ready !== 1'b1) $display("FAIL bad_restart_%0d: err=%b idx=%0d ready=%b want 0/0/1", bad_k, err, err_idx, in_ready); else n_pass++;
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_abort;
    done_seen = 0;
    do_start();
    for (int k = 0; k < 10; k++) begin
      send_word(pattern_word(k), 0);
      model_shadow[k] = pattern_word(k);
    end
    abort = 1'b1; in_valid = 1'b1; in_data = {3'd0, 3'd7};
    tick();
    abort = 1'b0; in_valid = 1'b0;
    n_total++; if (dbg_state !== 2'd0 || busy !== 1'b0 || err !== 1'b0) $display("FAIL abort_state: state=%0d busy=%b err=%b want 0/0/0", dbg_state, busy, err); else n_pass++;
    tick(); tick();
    n_total++; if (done_seen != 0 || cfg_active !== model_cfg) $display("FAIL abort_cfg: done_seen=%0d cfg=%h want 0/%h", done_seen, cfg_active, model_cfg); else n_pass++;
  endtask

  task automatic test_reset_mid_load;
    do_start();
    for (int k = 0; k < 5; k++) send_word(rand_word(k, 1'b1), 0);
    rst = 1'b1;
    tick();
    n_total++; if (cfg_active !== '0 || {done, err, err_idx, in_ready, busy} !== 9'd0) $display("FAIL midrst_outputs: cfg=%h flags=%b want 0", cfg_active, {done, err, err_idx, in_ready, busy}); else n_pass++;
    rst = 1'b0;
    for (int k = 0; k < NW; k++) model_shadow[k] = 6'd0;
    model_cfg = '0;
    tick();
    do_start();
    for (int k = 0; k < NW; k++) begin
      model_shadow[k] = rand_word(k, 1'b1);
      send_word(model_shadow[k], 2);
    end
    model_cfg = model_pack();
    wait_commit();
    n_total++; if (cfg_active !== model_cfg) $display("FAIL midrst_reload: got %h want %h", cfg_active, model_cfg); else n_pass++;
  endtask

  // Random mix of full loads, illegal words and aborts, with stray start pulses mid-load.
  task automatic test_random_loads(input int runs);
    int mode;
    int pos;
    logic [5:0] w;
    for (int r = 0; r < runs; r++) begin
      mode = $urandom_range(3, 0);
      pos  = $urandom_range(NW - 1, 0);
      done_seen = 0;
      do_start();
      n_total++; if (err !== 1'b0 || busy !== 1'b1) $display("FAIL rnd_start_%0d: err=%b busy=%b want 0/1", r, err, busy); else n_pass++;
      if (mode <= 1) begin
        for (int k = 0; k < NW; k++) begin
          start = (k < NW - 1) ? 1'($urandom_range(1, 0)) : 1'b0;
          model_shadow[k] = rand_word(k, 1'b1);
          send_word(model_shadow[k], 2);
        end
        start = 1'b0;
        model_cfg = model_pack();
        wait_commit();
        n_total++; if (cfg_active !== model_cfg || done_seen != 1) $display("FAIL rnd_commit_%0d: cfg=%h done_seen=%0d want %h/1", r, cfg_active, done_seen, model_cfg); else n_pass++;
      end else begin
        for (int k = 0; k < pos; k++) begin
          start = 1'($urandom_range(1, 0));
          model_shadow[k] = rand_word(k, 1'b1);
          send_word(model_shadow[k], 2);
        end
        start = 1'b0;
        if (mode == 2) begin
          w = rand_word(pos, 1'b0);
          send_word(w, 1);
          n_total++; if (err !== 1'b1 || err_idx !== 5'(pos) || cfg_active !== model_cfg) $display("FAIL rnd_err_%0d: err=%b idx=%0d cfg=%h want 1/%0d/%h", r, err, err_idx, cfg_active, pos, model_cfg); else n_pass++;
        end else begin
          abort = 1'b1; in_valid = 1'b1; in_data = rand_word(pos, 1'b0);
          tick();
          abort = 1'b0; in_valid = 1'b0;
          tick();
          n_total++; if (dbg_state !== 2'd0 || err !== 1'b0 || done_seen != 0 || cfg_active !== model_cfg) $display("FAIL rnd_abort_%0d: state=%0d err=%b done_seen=%0d cfg=%h want 0/0/0/%h", r, dbg_state, err, done_seen, cfg_active, model_cfg); else n_pass++;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 6'd0;
    build_dest_table();
    test_reset();
    test_full_load();
    test_gaps();
    test_bad_word(12, {3'd2, 3'd4});
    test_bad_word(15, {3'd4, 3'd2});
    test_bad_word(3,  {3'd0, 3'd7});
    test_abort();
    test_reset_mid_load();
    test_random_loads(24);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/switch_cfg_loader.md
SWITCH_CFG_LOADER -- requirements
Module: switch_cfg_loader

Interface
REQ-001 Parameter NTB, default 5: number of wires on the top side and on the bottom side; legal range 1..8.
REQ-002 Parameter NLR, default 4: number of wires on the left side and on the right side; legal range 1..8.
REQ-003 Derived constant NW = 2*NTB + 2*NLR (18 by default): number of config words; CW = 6*NW (108 by default).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  begin a load sequence; sampled in IDLE and ERR only.
REQ-007 abort  input  1  cancel a load in progress.
REQ-008 in_valid  input  1  in_data holds a valid config word.
REQ-009 in_data  input  6  config word: [2:0] source side code, [5:3] source wire index.
REQ-010 in_ready  output  1  block accepts a word this cycle.
REQ-011 cfg_active  output  CW  active switch-matrix configuration; word k at [6k+5:6k].
REQ-012 busy  output  1  high in LOAD and COMMIT.
REQ-013 done  output  1  one-cycle pulse on commit.
REQ-014 err  output  1  sticky error flag.
REQ-015 err_idx  output  5  destination index k of the rejected word.

Function
REQ-016 The destination order SHALL be: k=0..NTB-1 top[k]; NTB..2NTB-1 bottom; then NLR left; then NLR right.
REQ-017 Side codes SHALL be: 0 disconnected, 1 top, 2 right, 3 bottom, 4 left; codes 5..7 are illegal.
REQ-018 A word SHALL be legal only if: side code is 0 with index 0; or side 1/3 with index < NTB; or side 2/4 with index < NLR.
REQ-019 A word SHALL also be illegal when it selects its own destination (same side and same index), which would be a combinational self-loop.
REQ-020 States SHALL be IDLE, LOAD, COMMIT and ERR.
REQ-021 IDLE: in_ready=0; start=1 -> LOAD with cnt=0 and err cleared.
REQ-022 LOAD: in_ready=1; a word SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-023 A legal accepted word SHALL be written to shadow[cnt], then cnt increments.
REQ-024 If the accepted legal word has cnt=NW-1, the next state SHALL be COMMIT.
REQ-025 An illegal accepted word SHALL go to ERR, set err=1 and err_idx=cnt, and leave the shadow slot unwritten.
REQ-026 abort=1 in LOAD SHALL go to IDLE with cfg_active unchanged, and any word presented in that cycle SHALL NOT be accepted.
REQ-027 abort SHALL take priority over in_valid; start SHALL be ignored in LOAD and COMMIT.
REQ-028 COMMIT SHALL last exactly one cycle: cfg_active<=shadow and done<=1 on the same edge, then -> IDLE.
REQ-029 done and the new cfg_active SHALL first be visible in the same cycle, and done SHALL be high for exactly one cycle.
REQ-030 Latency: the last word accepted at edge N SHALL give the new cfg_active and done=1 after edge N+1.
REQ-031 ERR: in_ready=0; err and err_idx SHALL hold; start -> LOAD with cnt=0, err=0 and err_idx=0.
REQ-032 cfg_active SHALL change only in COMMIT; partial, aborted or errored loads SHALL never alter it.
REQ-033 The shadow SHALL retain words from the previous load; every full load overwrites all NW slots.
REQ-034 cnt SHALL be ceil(log2(NW)) bits wide and SHALL NOT wrap; the transition to COMMIT occurs at NW-1.

Reset
REQ-035 While rst=1, state SHALL be IDLE, and cnt, shadow, cfg_active, done, err and err_idx SHALL be 0.
REQ-036 While rst=1, in_ready=0 and busy=0; rst SHALL override start, abort and in_valid.
REQ-037 rst asserted mid-LOAD or in COMMIT SHALL force cfg_active to 0 (all wires disconnected) on that edge.

Verification
REQ-038 Full load: start, then 18 legal words with in_valid held high (word k = {3'd(k%4), 3'd2} for k<10, else {3'd0, 3'd1}) -> in_ready high for 18 cycles; one done pulse; cfg_active matches; busy falls after COMMIT.
REQ-039 Backpressure gaps: 18 legal words with random in_valid gaps -> same cfg_active as the gap-free load; done exactly once.
REQ-040 Illegal word: word 12 (left[2]) = {3'd2, 3'd4} (self-loop) -> err=1, err_idx=12, in_ready=0, cfg_active unchanged; then start clears err.
REQ-041 Out-of-range word: word 15 = {3'd4, 3'd2} (right index 4 >= NLR) -> err=1, err_idx=15; word 3 = {3'd0, 3'd7} (side code 7) -> err=1, err_idx=3.
REQ-042 Abort: abort after 10 words, asserted with in_valid=1 -> word not accepted, IDLE, no done, cfg_active equals the prior commit.
REQ-043 Reset mid-load: rst after 5 words -> all outputs 0 next cycle; a following full load commits correctly.
